slot_rng_ctrl: RTL and testbench
================================

# slot_rng_ctrl

Parametrised pseudo-random number generator and Gen2-style slot counter for the tag baseband. Supplies RN16 values to the command unit, loads/decrements the anti-collision slot counter, and now owns the Q register, including QueryAdjust up/down with saturation. It also adds a request/acknowledge port for handle (RN) capture. It sits between the command decoder/control unit and the reply encoder.

## Interface
- RNG_W, 16, LFSR and random-output width (≥ SLOT_W+1)
- SLOT_W, 15, slot counter width
- Q_W, 4, width of Q register
- Q_MAX, 15, upper saturation bound of Q (≤ SLOT_W)
- Q_INIT, 4, Q after reset
- POLY, 16'hB400, LFSR feedback tap mask
- SEED_RESET, 16'hBEAF, LFSR reset value; also substituted for an all-zero seed

Ports:
- clk_slot  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_seed_vld  in  1  load i_seed into LFSR
- i_seed  in  RNG_W  seed value (from ROM)
- i_rng_hold  in  1  freeze LFSR for this cycle
- i_q_load  in  1  Query: load Q from i_q
- i_q  in  Q_W  Q value from decoder
- i_q_adj  in  1  QueryAdjust strobe
- i_q_updn  in  3  Gen2 UpDn field: 3'b110 increment, 3'b011 decrement, others unchanged
- i_new_slot  in  1  load slot from random number
- i_dec_slot  in  1  QueryRep: decrement slot
- i_rn_req  in  1  capture random number as handle
- i_rn_ack  in  1  consumer accepted o_rn
- o_random  out  RNG_W  current LFSR state
- o_slot  out  SLOT_W  slot counter
- o_slotz  out  1  slot counter equals zero
- o_q  out  Q_W  current Q
- o_rn  out  RNG_W  captured handle
- o_rn_vld  out  1  o_rn valid

## Operation
- Reset values: o_random=SEED_RESET, o_slot=0, o_slotz=1, o_q=Q_INIT, o_rn=0, o_rn_vld=0.
- LFSR: Fibonacci; next = {cur[RNG_W-2:0], ^(cur & POLY)}. Priority: seed load > hold > advance. A seed of 0 loads SEED_RESET.
- Q update priority: i_q_load > i_q_adj. The load clamps to Q_MAX. Increment saturates at Q_MAX. Decrement saturates at 0.
- mask(q) = (1<<q)-1, truncated to SLOT_W; q=0 gives mask 0.
- Slot update priority:
  - i_new_slot, or i_q_adj with i_q_updn 110/011: slot <= o_random[SLOT_W-1:0] & mask(q_next). q_next is the Q value written on the same edge.
  - i_dec_slot: slot <= slot-1. 0 wraps to all-ones (7FFF for SLOT_W=15).
  - Otherwise hold.
- i_q_adj with UpDn 000 or any other code leaves both Q and slot unchanged. The slot is not redrawn.
- o_slotz = (o_slot == 0), decoded from the register.
- Handle FSM, states IDLE and VALID:
  - IDLE, i_rn_req=1: o_rn <= o_random, go to VALID.
  - VALID: o_rn and o_rn_vld are held stable. i_rn_ack=1 returns to IDLE.
  - i_rn_req while in VALID is ignored.
  - i_rn_req and i_rn_ack in the same cycle in VALID: ack is honoured, req is dropped.
- Reset asserted mid-operation returns every register to its reset value immediately.

## Timing
- All outputs are registered. Effects appear one clk_slot cycle after the sampling edge.
- The slot load samples o_random as it stands before the LFSR advances on that same edge.
- The handle capture samples the same pre-advance value. o_rn_vld rises 1 cycle after req and falls 1 cycle after ack.
- Seed to first advanced value: seed visible at cycle+1, first advanced value at cycle+2 unless held.

## Structure
- Shared package: UpDn encodings (UPDN_INC=3'b110, UPDN_DEC=3'b011), handle-FSM state typedef, SEED_RESET default.
- One natural sub-module: lfsr_core (parameters RNG_W, POLY, SEED_RESET; ports seed_vld, seed, hold, state). Q, slot and handle logic stay in the top.

## Test plan
- Reset release → o_random=16'hBEAF, o_slot=0, o_slotz=1, o_q=4, o_rn_vld=0. Next cycle o_random = BEAF advanced once per POLY.
- i_q_load with i_q=4, then i_new_slot while o_random=16'hBEAF → o_slot=15'h000F. Fifteen i_dec_slot pulses → o_slot=0, o_slotz=1. One more → o_slot=15'h7FFF, o_slotz=0.
- i_q=0 then i_new_slot → o_slot=0, o_slotz=1 regardless of o_random. i_seed_vld with i_seed=0 → o_random=16'hBEAF next cycle.
- o_q=15, i_q_adj with UpDn=110 → o_q stays 15 and slot is redrawn with mask 7FFF. o_q=0, UpDn=011 → o_q stays 0 and o_slot=0. UpDn=000 → Q and slot unchanged.
- i_new_slot and i_dec_slot in the same cycle → new-slot load wins. i_rng_hold for 3 cycles → o_random constant.
- i_rn_req while o_random=X → o_rn=X and o_rn_vld=1 next cycle. Further req ignored. o_rn stable until i_rn_ack, then o_rn_vld=0 one cycle later. Reset asserted while in VALID → o_rn_vld=0 immediately.

Source files
------------

// File: rtl/slot_rng_ctrl_pkg.sv
// Shared definitions for the RN16 generator / slot counter block.
// UpDn codes, handle-FSM states and LFSR defaults.
package slot_rng_ctrl_pkg;

    localparam logic [2:0] UPDN_INC = 3'b110;
    localparam logic [2:0] UPDN_DEC = 3'b011;

    localparam logic [15:0] SEED_RESET_DEF = 16'hBEAF;
    localparam logic [15:0] POLY_DEF       = 16'hB400;

    typedef enum logic {
        RN_IDLE  = 1'b0,
        RN_VALID = 1'b1
    } rn_state_t;

endpackage

// File: rtl/slot_rng_ctrl_lfsr_core.sv
// Fibonacci LFSR: shift left, parity of tapped bits enters at bit 0.
// Seed load beats hold; a zero seed is replaced by the reset value.
module lfsr_core #(
    parameter int             RNG_W      = 16,
    parameter logic [RNG_W-1:0] POLY       = 16'hB400,
    parameter logic [RNG_W-1:0] SEED_RESET = 16'hBEAF
) (
    input  logic             clk_slot,
    input  logic             rst_n,
    input  logic             i_seed_vld,
    input  logic [RNG_W-1:0] i_seed,
    input  logic             i_hold,
    output logic [RNG_W-1:0] o_state
);

    logic [RNG_W-1:0] r_state;
    logic [RNG_W-1:0] w_next;
    logic [RNG_W-1:0] w_seed;
    logic             w_fb;

    always_comb begin
        w_fb   = ^(r_state & POLY);
        w_next = {r_state[RNG_W-2:0], w_fb};
        // an all-zero state would lock the LFSR up
        w_seed = (i_seed == '0) ? SEED_RESET : i_seed;
    end

    always_ff @(posedge clk_slot or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEED_RESET;
        end else if (i_seed_vld) begin
            r_state <= w_seed;
        end else if (!i_hold) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/slot_rng_ctrl.sv
// RN16 source, Q register, anti-collision slot counter and
// handle capture port for the tag baseband.
module slot_rng_ctrl
    import slot_rng_ctrl_pkg::*;
#(
    parameter int               RNG_W      = 16,
    parameter int               SLOT_W     = 15,
    parameter int               Q_W        = 4,
    parameter int               Q_MAX      = 15,
    parameter int               Q_INIT     = 4,
    parameter logic [RNG_W-1:0] POLY       = POLY_DEF,
    parameter logic [RNG_W-1:0] SEED_RESET = SEED_RESET_DEF
) (
    input  logic              clk_slot,
    input  logic              rst_n,
    input  logic              i_seed_vld,
    input  logic [RNG_W-1:0]  i_seed,
    input  logic              i_rng_hold,
    input  logic              i_q_load,
    input  logic [Q_W-1:0]    i_q,
    input  logic              i_q_adj,
    input  logic [2:0]        i_q_updn,
    input  logic              i_new_slot,
    input  logic              i_dec_slot,
    input  logic              i_rn_req,
    input  logic              i_rn_ack,
    output logic [RNG_W-1:0]  o_random,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_slotz,
    output logic [Q_W-1:0]    o_q,
    output logic [RNG_W-1:0]  o_rn,
    output logic              o_rn_vld
);

    localparam logic [Q_W-1:0]    Q_MAX_V  = Q_W'(Q_MAX);
    localparam logic [Q_W-1:0]    Q_INIT_V = Q_W'(Q_INIT);
    localparam logic [Q_W-1:0]    Q_ONE    = Q_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);
    localparam logic [SLOT_W:0]   MASK_ONE = (SLOT_W+1)'(1);

    function automatic logic [SLOT_W-1:0] slot_mask(
        input logic [Q_W-1:0] q
    );
        logic [SLOT_W:0] m;
        m = (MASK_ONE << q) - MASK_ONE;
        return m[SLOT_W-1:0];
    endfunction

    logic [RNG_W-1:0]  w_random;
    logic [Q_W-1:0]    r_q;
    logic [Q_W-1:0]    w_q_next;
    logic [SLOT_W-1:0] r_slot;
    logic [SLOT_W-1:0] w_slot_next;
    logic              w_updn_inc;
    logic              w_updn_dec;
    logic              w_redraw;
    rn_state_t         r_rn_state;
    rn_state_t         w_rn_state_next;
    logic [RNG_W-1:0]  r_rn;
    logic              w_rn_capture;

    lfsr_core #(
        .RNG_W      (RNG_W),
        .POLY       (POLY),
        .SEED_RESET (SEED_RESET)
    ) u_lfsr (
        .clk_slot   (clk_slot),
        .rst_n      (rst_n),
        .i_seed_vld (i_seed_vld),
        .i_seed     (i_seed),
        .i_hold     (i_rng_hold),
        .o_state    (w_random)
    );

    always_comb begin
        w_updn_inc = i_q_adj && (i_q_updn == UPDN_INC);
        w_updn_dec = i_q_adj && (i_q_updn == UPDN_DEC);
        w_q_next   = r_q;
        priority case (1'b1)
            i_q_load:
                w_q_next = (i_q > Q_MAX_V) ? Q_MAX_V : i_q;
            w_updn_inc:
                w_q_next = (r_q >= Q_MAX_V) ? Q_MAX_V : r_q + Q_ONE;
            w_updn_dec:
                w_q_next = (r_q == '0) ? '0 : r_q - Q_ONE;
            default: ;
        endcase
    end

    // redraw uses the Q being written this edge and the pre-advance LFSR
    always_comb begin
        w_redraw    = i_new_slot || w_updn_inc || w_updn_dec;
        w_slot_next = r_slot;
        priority case (1'b1)
            w_redraw:
                w_slot_next = w_random[SLOT_W-1:0] & slot_mask(w_q_next);
            i_dec_slot:
                w_slot_next = r_slot - SLOT_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk_slot or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= Q_INIT_V;
            r_slot <= '0;
        end else begin
            r_q    <= w_q_next;
            r_slot <= w_slot_next;
        end
    end

    always_ff @(posedge clk_slot or negedge rst_n) begin
        if (!rst_n) begin
            r_rn_state <= RN_IDLE;
        end else begin
            r_rn_state <= w_rn_state_next;
        end
    end

    // ack always wins in VALID; a concurrent req is simply dropped
    always_comb begin
        w_rn_state_next = r_rn_state;
        unique case (r_rn_state)
            RN_IDLE:
                if (i_rn_req) w_rn_state_next = RN_VALID;
            RN_VALID:
                if (i_rn_ack) w_rn_state_next = RN_IDLE;
            default:
                w_rn_state_next = RN_IDLE;
        endcase
    end

    always_comb begin
        w_rn_capture = (r_rn_state == RN_IDLE) && i_rn_req;
        o_rn_vld     = (r_rn_state == RN_VALID);
    end

    always_ff @(posedge clk_slot or negedge rst_n) begin
        if (!rst_n) begin
            r_rn <= '0;
        end else if (w_rn_capture) begin
            r_rn <= w_random;
        end
    end

    assign o_random = w_random;
    assign o_slot   = r_slot;
    assign o_slotz  = (r_slot == '0);
    assign o_q      = r_q;
    assign o_rn     = r_rn;

endmodule

// File: tb/tb_slot_rng_ctrl.sv
// Directed bench for slot_rng_ctrl: LFSR, Q, slot and handle port.
// Expected values are hand-computed from the LFSR polynomial.
module tb_slot_rng_ctrl;

    logic        clk_slot;
    logic        rst_n;
    logic        i_seed_vld;
    logic [15:0] i_seed;
    logic        i_rng_hold;
    logic        i_q_load;
    logic [3:0]  i_q;
    logic        i_q_adj;
    logic [2:0]  i_q_updn;
    logic        i_new_slot;
    logic        i_dec_slot;
    logic        i_rn_req;
    logic        i_rn_ack;
    logic [15:0] o_random;
    logic [14:0] o_slot;
    logic        o_slotz;
    logic [3:0]  o_q;
    logic [15:0] o_rn;
    logic        o_rn_vld;

    int n_chk;
    int n_err;

    slot_rng_ctrl dut (
        .clk_slot   (clk_slot),
        .rst_n      (rst_n),
        .i_seed_vld (i_seed_vld),
        .i_seed     (i_seed),
        .i_rng_hold (i_rng_hold),
        .i_q_load   (i_q_load),
        .i_q        (i_q),
        .i_q_adj    (i_q_adj),
        .i_q_updn   (i_q_updn),
        .i_new_slot (i_new_slot),
        .i_dec_slot (i_dec_slot),
        .i_rn_req   (i_rn_req),
        .i_rn_ack   (i_rn_ack),
        .o_random   (o_random),
        .o_slot     (o_slot),
        .o_slotz    (o_slotz),
        .o_q        (o_q),
        .o_rn       (o_rn),
        .o_rn_vld   (o_rn_vld)
    );

    initial clk_slot = 1'b0;
    always #5 clk_slot = ~clk_slot;

    task automatic check_eq(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_slot);
        #1;
    endtask

    task automatic clr_in();
        i_seed_vld = 0; i_seed = '0; i_rng_hold = 0;
        i_q_load = 0; i_q = '0; i_q_adj = 0; i_q_updn = 3'b000;
        i_new_slot = 0; i_dec_slot = 0; i_rn_req = 0; i_rn_ack = 0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        clr_in();
        rst_n = 0;
        repeat (2) tick();
        rst_n = 1;
        check_eq("rst_random", 32'(o_random), 32'hBEAF);
        check_eq("rst_slot", 32'(o_slot), 32'h0);
        check_eq("rst_slotz", 32'(o_slotz), 32'h1);
        check_eq("rst_q", 32'(o_q), 32'h4);
        check_eq("rst_rn", 32'(o_rn), 32'h0);
        check_eq("rst_rn_vld", 32'(o_rn_vld), 32'h0);
        tick();
        check_eq("adv_once", 32'(o_random), 32'h7D5E);

        // Q=4, slot drawn from BEAF
        i_seed_vld = 1; i_seed = 16'hBEAF; i_q_load = 1; i_q = 4;
        tick();
        check_eq("seed_beaf", 32'(o_random), 32'hBEAF);
        check_eq("q_load4", 32'(o_q), 32'h4);
        clr_in();
        i_new_slot = 1;
        tick();
        check_eq("slot_f", 32'(o_slot), 32'h000F);
        check_eq("adv_after_slot", 32'(o_random), 32'h7D5E);
        clr_in();
        i_dec_slot = 1;
        repeat (14) tick();
        check_eq("dec14", 32'(o_slot), 32'h1);
        check_eq("dec14_z", 32'(o_slotz), 32'h0);
        tick();
        check_eq("dec15", 32'(o_slot), 32'h0);
        check_eq("dec15_z", 32'(o_slotz), 32'h1);
        tick();
        check_eq("dec_wrap", 32'(o_slot), 32'h7FFF);
        check_eq("dec_wrap_z", 32'(o_slotz), 32'h0);
        clr_in();

        // Q=0 gives an empty mask
        i_q_load = 1; i_q = 0;
        tick();
        check_eq("q_load0", 32'(o_q), 32'h0);
        clr_in();
        i_new_slot = 1;
        tick();
        check_eq("slot_q0", 32'(o_slot), 32'h0);
        check_eq("slot_q0_z", 32'(o_slotz), 32'h1);
        clr_in();

        // zero seed falls back to reset seed
        i_seed_vld = 1; i_seed = 16'h0000;
        tick();
        check_eq("seed_zero", 32'(o_random), 32'hBEAF);
        clr_in();
        tick();
        check_eq("seed_zero_adv", 32'(o_random), 32'h7D5E);

        // Q saturation high and redraw with full mask
        i_seed_vld = 1; i_seed = 16'h1234; i_q_load = 1; i_q = 15;
        tick();
        check_eq("q_load15", 32'(o_q), 32'hF);
        clr_in();
        i_q_adj = 1; i_q_updn = 3'b110;
        tick();
        check_eq("q_inc_sat", 32'(o_q), 32'hF);
        check_eq("slot_mask7fff", 32'(o_slot), 32'h1234);
        check_eq("adv_1234", 32'(o_random), 32'h2469);
        i_q_updn = 3'b011;
        tick();
        check_eq("q_dec", 32'(o_q), 32'hE);
        check_eq("slot_mask3fff", 32'(o_slot), 32'h2469);
        i_q_updn = 3'b000;
        tick();
        check_eq("updn000_q", 32'(o_q), 32'hE);
        check_eq("updn000_slot", 32'(o_slot), 32'h2469);
        i_q_updn = 3'b111;
        tick();
        check_eq("updn111_q", 32'(o_q), 32'hE);
        check_eq("updn111_slot", 32'(o_slot), 32'h2469);
        clr_in();

        // Q saturation low
        i_q_load = 1; i_q = 0;
        tick();
        clr_in();
        i_q_adj = 1; i_q_updn = 3'b011;
        tick();
        check_eq("q_dec_sat", 32'(o_q), 32'h0);
        check_eq("slot_dec_sat", 32'(o_slot), 32'h0);
        clr_in();

        // new_slot beats dec_slot
        i_seed_vld = 1; i_seed = 16'h00A5; i_q_load = 1; i_q = 8;
        tick();
        clr_in();
        i_new_slot = 1; i_dec_slot = 1;
        tick();
        check_eq("new_over_dec", 32'(o_slot), 32'h00A5);
        clr_in();

        // hold freezes, release advances
        i_seed_vld = 1; i_seed = 16'hC0DE;
        tick();
        clr_in();
        i_rng_hold = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("hold", 32'(o_random), 32'hC0DE);
        end
        i_seed_vld = 1; i_seed = 16'h5555;
        tick();
        check_eq("seed_over_hold", 32'(o_random), 32'h5555);
        clr_in();
        i_seed_vld = 1; i_seed = 16'hC0DE;
        tick();
        clr_in();
        tick();
        check_eq("adv_c0de", 32'(o_random), 32'h81BD);

        // handle capture
        i_rn_req = 1;
        tick();
        check_eq("rn_cap", 32'(o_rn), 32'h81BD);
        check_eq("rn_vld1", 32'(o_rn_vld), 32'h1);
        tick();
        check_eq("rn_req_ign", 32'(o_rn), 32'h81BD);
        check_eq("rn_vld2", 32'(o_rn_vld), 32'h1);
        i_rn_req = 0;
        tick();
        check_eq("rn_stable", 32'(o_rn), 32'h81BD);
        i_rn_req = 1; i_rn_ack = 1;
        tick();
        check_eq("rn_ack", 32'(o_rn_vld), 32'h0);
        clr_in();
        tick();
        check_eq("rn_idle", 32'(o_rn_vld), 32'h0);
        i_rn_req = 1;
        tick();
        check_eq("rn_vld3", 32'(o_rn_vld), 32'h1);
        clr_in();

        // asynchronous reset mid-operation
        #2 rst_n = 0;
        #1;
        check_eq("arst_rn_vld", 32'(o_rn_vld), 32'h0);
        check_eq("arst_rn", 32'(o_rn), 32'h0);
        check_eq("arst_q", 32'(o_q), 32'h4);
        check_eq("arst_slot", 32'(o_slot), 32'h0);
        check_eq("arst_random", 32'(o_random), 32'hBEAF);
        tick();
        rst_n = 1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
